// File: rtl/ctrl_if.sv
// Decoder-facing bundle for ctrl_unit.
// The run controls and instruction come in, and the gated control bundle goes out.
interface ctrl_if #(
    parameter int N = 32
);
    logic [31:0]  instruction;
    logic         start;
    logic         step;
    logic         stop;
    logic         run;
    logic         RegWr;
    logic         Branch;
    logic         Jump;
    logic         MemWr;
    logic         ExtOp;
    logic         AluSrc;
    logic         MemtoReg;
    logic         RegDst;
    logic [2:0]   Aluctr;
    logic [2:0]   state;
    logic [N-1:0] ins_count;

    modport master (
        output instruction, start, step, stop,
        input  run, RegWr, Branch, Jump, MemWr,
        input  ExtOp, AluSrc, MemtoReg, RegDst,
        input  Aluctr, state, ins_count
    );

    modport slave (
        input  instruction, start, step, stop,
        output run, RegWr, Branch, Jump, MemWr,
        output ExtOp, AluSrc, MemtoReg, RegDst,
        output Aluctr, state, ins_count
    );
endinterface

// File: rtl/ctrl_unit.sv
// Main decoder for the single-cycle MIPS core.
// A run/step/halt FSM gates side effects and counts retirements.
module ctrl_unit #(
    parameter int N = 32
) (
    input  logic   clk,
    input  logic   rst,
    ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        RUN   = 3'b001,
        STEP  = 3'b010,
        HALT  = 3'b011,
        ERROR = 3'b100
    } state_e;

    state_e       state_q;
    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    logic [5:0] op;
    logic [5:0] func;
    logic       unused_bits;

    assign op          = bus.instruction[31:26];
    assign func        = bus.instruction[5:0];
    assign unused_bits = ^bus.instruction[25:6];

    logic       reg_wr;
    logic       branch;
    logic       jump;
    logic       mem_wr;
    logic       ext_op;
    logic       alu_src;
    logic       mem2reg;
    logic       reg_dst;
    logic [2:0] alu_ctr;
    logic       halt;
    logic       illegal;
    logic       exec;

    always_comb begin
        reg_wr  = 1'b0;
        branch  = 1'b0;
        jump    = 1'b0;
        mem_wr  = 1'b0;
        ext_op  = 1'b0;
        alu_src = 1'b0;
        mem2reg = 1'b0;
        reg_dst = 1'b0;
        alu_ctr = 3'b000;
        halt    = 1'b0;
        illegal = 1'b0;
        case (op)
            6'b000000: begin
                reg_dst = 1'b1;
                reg_wr  = 1'b1;
                case (func)
                    6'b100000: alu_ctr = 3'b000;
                    6'b100001: alu_ctr = 3'b101;
                    6'b100010: alu_ctr = 3'b001;
                    6'b100011: alu_ctr = 3'b110;
                    6'b100100: alu_ctr = 3'b010;
                    6'b100101: alu_ctr = 3'b011;
                    6'b101010: alu_ctr = 3'b100;
                    default:   illegal = 1'b1;
                endcase
            end
            6'b001000: begin
                reg_wr  = 1'b1;
                alu_src = 1'b1;
                ext_op  = 1'b1;
                alu_ctr = 3'b000;
            end
            6'b001101: begin
                reg_wr  = 1'b1;
                alu_src = 1'b1;
                alu_ctr = 3'b011;
            end
            6'b100011: begin
                reg_wr  = 1'b1;
                alu_src = 1'b1;
                ext_op  = 1'b1;
                mem2reg = 1'b1;
                alu_ctr = 3'b101;
            end
            6'b101011: begin
                mem_wr  = 1'b1;
                alu_src = 1'b1;
                ext_op  = 1'b1;
                alu_ctr = 3'b101;
            end
            6'b000100: begin
                branch  = 1'b1;
                alu_ctr = 3'b110;
            end
            6'b000010: jump = 1'b1;
            6'b111111: halt = 1'b1;
            default:   illegal = 1'b1;
        endcase
        // An illegal word must not leak any partial R-type decode.
        if (illegal) begin
            reg_wr  = 1'b0;
            reg_dst = 1'b0;
            alu_ctr = 3'b000;
        end
    end

    assign exec = ((state_q == RUN) || (state_q == STEP))
                  && !halt && !illegal;

    assign cnt_d = exec ? cnt_q + N'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (bus.start)     state_q <= RUN;
                    else if (bus.step) state_q <= STEP;
                end
                RUN: begin
                    if (halt)          state_q <= HALT;
                    else if (illegal)  state_q <= ERROR;
                    else if (bus.stop) state_q <= IDLE;
                end
                STEP: begin
                    if (halt)          state_q <= HALT;
                    else if (illegal)  state_q <= ERROR;
                    else               state_q <= IDLE;
                end
                HALT:    state_q <= HALT;
                ERROR:   state_q <= ERROR;
                default: state_q <= ERROR;
            endcase
        end
    end

    assign bus.run       = exec;
    assign bus.RegWr     = reg_wr & exec;
    assign bus.Branch    = branch & exec;
    assign bus.Jump      = jump & exec;
    assign bus.MemWr     = mem_wr & exec;
    assign bus.ExtOp     = ext_op;
    assign bus.AluSrc    = alu_src;
    assign bus.MemtoReg  = mem2reg;
    assign bus.RegDst    = reg_dst;
    assign bus.Aluctr    = alu_ctr;
    assign bus.state     = state_q;
    assign bus.ins_count = cnt_q;
endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit against a table-driven reference model.
// A second, 4-bit-counter instance covers counter wrap.
module tb_ctrl_unit;
    logic clk;
    logic rst;
    logic rst4;

    ctrl_if #(.N(32)) bus();
    ctrl_if #(.N(4))  b4();

    ctrl_unit #(.N(32)) dut  (.clk(clk), .rst(rst),  .bus(bus.slave));
    ctrl_unit #(.N(4))  dut4 (.clk(clk), .rst(rst4), .bus(b4.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nvec;
    int nerr;

    logic [2:0]  mstate;
    logic [31:0] mcnt;
    logic [31:0] cw;
    logic        cs, cp, co;
    logic [46:0] exp_v;
    logic [46:0] obs_v;

    localparam logic [31:0] ADDU = 32'h00221821;
    localparam logic [31:0] ADD  = 32'h00221820;
    localparam logic [31:0] SUB  = 32'h00221822;
    localparam logic [31:0] ADDI = 32'h20410005;
    localparam logic [31:0] ORI  = 32'h3441F0F0;
    localparam logic [31:0] LW   = 32'h8C410004;
    localparam logic [31:0] SW   = 32'hAC410008;
    localparam logic [31:0] BEQ  = 32'h10220003;
    localparam logic [31:0] JMP  = 32'h08000010;
    localparam logic [31:0] HLT  = 32'hFC000000;
    localparam logic [31:0] ILOP = 32'h40000000;
    localparam logic [31:0] ILFN = 32'h00000007;

    // {illegal, halt, RegWr, Branch, Jump, MemWr, ExtOp, AluSrc, MemtoReg, RegDst, Aluctr}
    function automatic logic [12:0] ref_dec(input logic [31:0] w);
        logic [5:0]  op;
        logic [5:0]  f;
        logic [10:0] c;
        logic        il;
        logic        h;
        op = w[31:26];
        f  = w[5:0];
        il = 1'b0;
        h  = 1'b0;
        c  = '0;
        if (op == 6'h00) begin
            c = {8'b1000_0001, 3'd0};
            if      (f == 6'h20) c[2:0] = 3'd0;
            else if (f == 6'h21) c[2:0] = 3'd5;
            else if (f == 6'h22) c[2:0] = 3'd1;
            else if (f == 6'h23) c[2:0] = 3'd6;
            else if (f == 6'h24) c[2:0] = 3'd2;
            else if (f == 6'h25) c[2:0] = 3'd3;
            else if (f == 6'h2a) c[2:0] = 3'd4;
            else il = 1'b1;
        end
        else if (op == 6'h08) c = {8'b1000_1100, 3'd0};
        else if (op == 6'h0d) c = {8'b1000_0100, 3'd3};
        else if (op == 6'h23) c = {8'b1000_1110, 3'd5};
        else if (op == 6'h2b) c = {8'b0001_1100, 3'd5};
        else if (op == 6'h04) c = {8'b0100_0000, 3'd6};
        else if (op == 6'h02) c = {8'b0010_0000, 3'd0};
        else if (op == 6'h3f) h = 1'b1;
        else il = 1'b1;
        if (il) c = '0;
        return {il, h, c};
    endfunction

    function automatic logic model_exec(input logic [31:0] w);
        logic [12:0] d;
        d = ref_dec(w);
        return (mstate == 3'd1 || mstate == 3'd2) && !d[12] && !d[11];
    endfunction

    function automatic logic [46:0] model_vec(input logic [31:0] w);
        logic [12:0] d;
        logic        ex;
        d  = ref_dec(w);
        ex = model_exec(w);
        return {ex, d[10] & ex, d[9] & ex, d[8] & ex, d[7] & ex,
                d[6:3], d[2:0], mstate, mcnt};
    endfunction

    function automatic logic [46:0] dut_vec();
        return {bus.run, bus.RegWr, bus.Branch, bus.Jump, bus.MemWr,
                bus.ExtOp, bus.AluSrc, bus.MemtoReg, bus.RegDst,
                bus.Aluctr, bus.state, bus.ins_count};
    endfunction

    task automatic cyc(input logic [31:0] w, input logic s,
                       input logic p, input logic o);
        cw = w; cs = s; cp = p; co = o;
        bus.instruction = w;
        bus.start = s;
        bus.step  = p;
        bus.stop  = o;
        @(negedge clk);
        exp_v = model_vec(w);
        obs_v = dut_vec();
    endtask

    task automatic adv();
        logic [12:0] d;
        logic        ex;
        logic [2:0]  ns;
        logic [31:0] nc;
        d  = ref_dec(cw);
        ex = model_exec(cw);
        ns = mstate;
        nc = ex ? mcnt + 32'd1 : mcnt;
        if (mstate == 3'd0) begin
            if (cs) ns = 3'd1;
            else if (cp) ns = 3'd2;
        end else if (mstate == 3'd1) begin
            if (d[11]) ns = 3'd3;
            else if (d[12]) ns = 3'd4;
            else if (co) ns = 3'd0;
        end else if (mstate == 3'd2) begin
            if (d[11]) ns = 3'd3;
            else if (d[12]) ns = 3'd4;
            else ns = 3'd0;
        end
        if (rst) begin
            ns = 3'd0;
            nc = 32'd0;
        end
        @(posedge clk);
        #1;
        mstate = ns;
        mcnt   = nc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(ADDU, 1'b0, 1'b0, 1'b0);
        adv();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(ADDU, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        mstate = 3'd0;
        mcnt   = 32'd0;
        for (int i = 0; i < 2; i++) begin
            cyc(ADDU, 1'b0, 1'b0, 1'b0);
            nvec++;
            if (obs_v !== exp_v) begin
                nerr++;
                $display("FAIL reset[%0d] got %h want %h", i, obs_v, exp_v);
            end
            adv();
        end
        rst = 1'b0;
        cyc(ADDU, 1'b0, 1'b0, 1'b0);
        nvec++;
        if (bus.RegDst !== 1'b1 || bus.Aluctr !== 3'b101
            || bus.run !== 1'b0 || bus.state !== 3'b000) begin
            nerr++;
            $display("FAIL reset_idle got rd=%b alu=%b run=%b st=%b want 1 101 0 000",
                     bus.RegDst, bus.Aluctr, bus.run, bus.state);
        end
        adv();
    endtask

    task automatic test_decode_sweep();
        logic [31:0] seq [8];
        seq = '{ADDU, ADDI, ORI, LW, SW, BEQ, JMP, SUB};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(seq[i], i == 0, 1'b0, 1'b0);
            nvec++;
            if (obs_v !== exp_v) begin
                nerr++;
                $display("FAIL sweep[%0d] got %h want %h", i, obs_v, exp_v);
            end
            adv();
        end
        cyc(ADD, 1'b0, 1'b0, 1'b1);
        nvec++;
        if (bus.ins_count !== 32'd7 || obs_v !== exp_v) begin
            nerr++;
            $display("FAIL sweep_count got %0d want 7 (vec %h want %h)",
                     bus.ins_count, obs_v, exp_v);
        end
        adv();
        cyc(ADD, 1'b0, 1'b0, 1'b0);
        nvec++;
        if (bus.state !== 3'b000 || bus.ins_count !== 32'd8) begin
            nerr++;
            $display("FAIL stop got st=%b cnt=%0d want 000 8",
                     bus.state, bus.ins_count);
        end
        adv();
    endtask

    task automatic test_step();
        do_reset();
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 3; i++) begin
                cyc(ADD, 1'b0, i == 0, 1'b0);
                nvec++;
                if (obs_v !== exp_v) begin
                    nerr++;
                    $display("FAIL step%0d[%0d] got %h want %h", n, i, obs_v, exp_v);
                end
                adv();
            end
        end
        cyc(ADD, 1'b0, 1'b0, 1'b0);
        nvec++;
        if (bus.ins_count !== 32'd2 || bus.state !== 3'b000) begin
            nerr++;
            $display("FAIL step_count got %0d st=%b want 2 000",
                     bus.ins_count, bus.state);
        end
        adv();
    endtask

    task automatic test_halt();
        logic [31:0] seq [6];
        seq = '{ADD, ADDI, HLT, HLT, ADD, ADD};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(seq[i], i == 0 || i > 2, 1'b0, 1'b0);
            nvec++;
            if (obs_v !== exp_v) begin
                nerr++;
                $display("FAIL halt[%0d] got %h want %h", i, obs_v, exp_v);
            end
            adv();
        end
        cyc(ADD, 1'b1, 1'b1, 1'b0);
        nvec++;
        if (bus.state !== 3'b011 || bus.ins_count !== 32'd1 || bus.run !== 1'b0) begin
            nerr++;
            $display("FAIL halt_sticky got st=%b cnt=%0d run=%b want 011 1 0",
                     bus.state, bus.ins_count, bus.run);
        end
        adv();
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad = '{ILOP, ILFN};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < 4; i++) begin
                cyc(i == 2 ? bad[k] : ADD, i == 0, 1'b0, 1'b0);
                nvec++;
                if (obs_v !== exp_v) begin
                    nerr++;
                    $display("FAIL illegal%0d[%0d] got %h want %h", k, i, obs_v, exp_v);
                end
                adv();
            end
            cyc(bad[k], 1'b0, 1'b0, 1'b0);
            nvec++;
            if (bus.state !== 3'b100 || obs_v[46:38] !== 9'd0
                || bus.Aluctr !== 3'd0) begin
                nerr++;
                $display("FAIL illegal%0d_ctl got st=%b ctl=%b alu=%b want 100 0 000",
                         k, bus.state, obs_v[46:38], bus.Aluctr);
            end
            adv();
        end
    endtask

    task automatic test_priority();
        do_reset();
        cyc(ADD, 1'b1, 1'b0, 1'b0); adv();
        cyc(HLT, 1'b0, 1'b0, 1'b1); adv();
        cyc(ADD, 1'b0, 1'b0, 1'b0);
        nvec++;
        if (bus.state !== 3'b011) begin
            nerr++;
            $display("FAIL halt_over_stop got %b want 011", bus.state);
        end
        adv();
        do_reset();
        cyc(ADD, 1'b1, 1'b1, 1'b0); adv();
        cyc(ADD, 1'b0, 1'b0, 1'b0); adv();
        rst = 1'b1;
        cyc(ADD, 1'b1, 1'b1, 1'b1); adv();
        rst = 1'b0;
        cyc(ADD, 1'b0, 1'b0, 1'b0);
        nvec++;
        if (bus.state !== 3'b000 || bus.ins_count !== 32'd0) begin
            nerr++;
            $display("FAIL rst_mid_run got st=%b cnt=%0d want 000 0",
                     bus.state, bus.ins_count);
        end
        adv();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [5:0]  ops [8];
        logic [5:0]  fns [7];
        int          k;
        ops = '{6'h00, 6'h08, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h00};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a};
        w = $urandom;
        k = $urandom_range(0, 19);
        if (k < 16) w[31:26] = ops[k % 8];
        else if (k == 16) w[31:26] = 6'h3f;
        if (w[31:26] == 6'h00 && k < 15) w[5:0] = fns[$urandom_range(0, 6)];
        return w;
    endfunction

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = (mstate >= 3'd3 && $urandom_range(0, 2) == 0)
                  || $urandom_range(0, 49) == 0;
            cyc(rand_word(), $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            nvec++;
            if (obs_v !== exp_v) begin
                nerr++;
                $display("FAIL random[%0d] w=%h got %h want %h", i, cw, obs_v, exp_v);
            end
            adv();
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        b4.instruction = ADDU;
        b4.start = 1'b0;
        b4.step  = 1'b0;
        b4.stop  = 1'b0;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        b4.start = 1'b1;
        @(posedge clk); #1;
        b4.start = 1'b0;
        nvec++;
        if (b4.ins_count !== 4'd0 || b4.state !== 3'b001) begin
            nerr++;
            $display("FAIL wrap_start got cnt=%0d st=%b want 0 001",
                     b4.ins_count, b4.state);
        end
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            nvec++;
            if (b4.ins_count !== 4'((k + 1) % 16)) begin
                nerr++;
                $display("FAIL wrap[%0d] got %0d want %0d",
                         k, b4.ins_count, (k + 1) % 16);
            end
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        mstate = 3'd0;
        mcnt = 32'd0;
        rst = 1'b1;
        rst4 = 1'b1;
        b4.instruction = ADDU;
        b4.start = 1'b0;
        b4.step  = 1'b0;
        b4.stop  = 1'b0;
        test_reset();
        test_decode_sweep();
        test_step();
        test_halt();
        test_illegal();
        test_priority();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
